// File: rtl/wr_pack_pkg.sv
// Shared types and helpers for the write-side byte packer.
package wr_pack_pkg;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        WAIT = 1'b1
    } pack_state_e;

    localparam logic [7:0] PAD_DEFAULT = 8'h00;

    function automatic int lanes_f(input int wr_width, input int width);
        return wr_width / width;
    endfunction

endpackage

// File: rtl/wr_byte_packer_sat_counter.sv
// Saturating event counter: increments on i_inc and sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count, held once every bit is set
    always_comb begin
        cnt_d = cnt_q;
        if (i_inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt = cnt_q;

endmodule

// File: rtl/wr_byte_packer.sv
// Packs a valid/ready byte stream into FIFO-width words, with an accumulator
// plus output register so intake continues while one word waits on a full FIFO.
module wr_byte_packer
    import wr_pack_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               WR_WIDTH = 64,
    parameter int               LANES    = lanes_f(WR_WIDTH, WIDTH),
    parameter logic [WIDTH-1:0] PAD      = WIDTH'(PAD_DEFAULT),
    parameter int               CNT_W    = 32
) (
    input  logic                i_wr_clk,
    input  logic                i_wr_rstn,
    input  logic                i_s_valid,
    output logic                o_s_ready,
    input  logic [WIDTH-1:0]    i_s_data,
    input  logic                i_s_last,
    input  logic                i_flush,
    output logic                o_wr_en,
    output logic [WR_WIDTH-1:0] o_wr_data,
    input  logic                i_wr_full,
    output logic                o_busy,
    output logic [CNT_W-1:0]    o_word_cnt,
    output logic [CNT_W-1:0]    o_stall_cnt,
    output logic [CNT_W-1:0]    o_pad_cnt
);

    localparam int                LANE_W    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    pack_state_e         state_q, state_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [WR_WIDTH-1:0] acc_q, acc_d;
    logic [WR_WIDTH-1:0] out_q, out_d;
    logic                pend_q, pend_d;

    logic                accept_s, push_s, commit_s, padded_s;
    logic [LANE_W-1:0]   last_lane_s;
    logic [WR_WIDTH-1:0] acc_ins_s, word_s;

    // Intake, commit/padding and output-register handoff
    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        acc_d       = acc_q;
        out_d       = out_q;
        pend_d      = pend_q;
        commit_s    = 1'b0;
        acc_ins_s   = acc_q;
        word_s      = '0;
        push_s      = pend_q && !i_wr_full;
        accept_s    = i_s_valid && (state_q == FILL);

        if (push_s) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end

        // The byte lands before any same-cycle flush, so it counts as written
        if (accept_s) begin
            acc_ins_s[int'(lane_q)*WIDTH +: WIDTH] = i_s_data;
            last_lane_s = lane_q;
        end else begin
            last_lane_s = lane_q - LANE_W'(1);
        end

        for (int l = 0; l < LANES; l++) begin
            if (LANE_W'(l) > last_lane_s) begin
                word_s[l*WIDTH +: WIDTH] = PAD;
            end else begin
                word_s[l*WIDTH +: WIDTH] = acc_ins_s[l*WIDTH +: WIDTH];
            end
        end
        padded_s = (last_lane_s != LAST_LANE);

        case (state_q)
            FILL: begin
                if (accept_s) begin
                    commit_s = (lane_q == LAST_LANE) || i_s_last || i_flush;
                end else begin
                    commit_s = i_flush && (lane_q != '0);
                end

                if (commit_s) begin
                    lane_d = '0;
                    if (!pend_q || push_s) begin
                        out_d  = word_s;
                        pend_d = 1'b1;
                        acc_d  = '0;
                    end else begin
                        acc_d   = word_s;
                        state_d = WAIT;
                    end
                end else if (accept_s) begin
                    acc_d  = acc_ins_s;
                    lane_d = lane_q + LANE_W'(1);
                end else begin
                    acc_d = acc_q;
                end
            end
            WAIT: begin
                // Flush is ignored here; the parked word moves up on the push
                if (push_s) begin
                    out_d   = acc_q;
                    pend_d  = 1'b1;
                    acc_d   = '0;
                    state_d = FILL;
                end else begin
                    state_d = WAIT;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // Packer state, accumulator and output register
    always_ff @(posedge i_wr_clk or negedge i_wr_rstn) begin
        if (!i_wr_rstn) begin
            state_q <= FILL;
            lane_q  <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            pend_q  <= pend_d;
        end
    end

    assign o_s_ready = (state_q == FILL);
    assign o_wr_en   = pend_q;
    assign o_wr_data = out_q;
    assign o_busy    = (lane_q != '0) || pend_q || (state_q == WAIT);

    sat_counter #(.W(CNT_W)) u_word_cnt (
        .i_clk  (i_wr_clk),
        .i_rstn (i_wr_rstn),
        .i_inc  (push_s),
        .o_cnt  (o_word_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .i_clk  (i_wr_clk),
        .i_rstn (i_wr_rstn),
        .i_inc  (pend_q && i_wr_full),
        .o_cnt  (o_stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_pad_cnt (
        .i_clk  (i_wr_clk),
        .i_rstn (i_wr_rstn),
        .i_inc  (commit_s && padded_s),
        .o_cnt  (o_pad_cnt)
    );

endmodule

// File: tb/tb_wr_byte_packer.sv
// Bench for wr_byte_packer: directed vector table, hand sequences for reset and
// backpressure, and random traffic against a transaction-level byte/word model.
module tb_wr_byte_packer;

    localparam int WIDTH = 8;
    localparam int WR_W  = 64;
    localparam int LANES = 8;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [WIDTH-1:0] s_data = '0;
    logic             s_last = 1'b0;
    logic             flush = 1'b0;
    logic             wr_en;
    logic [WR_W-1:0]  wr_data;
    logic             wr_full = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] word_cnt, stall_cnt, pad_cnt;

    wr_byte_packer dut (
        .i_wr_clk    (clk),
        .i_wr_rstn   (rstn),
        .i_s_valid   (s_valid),
        .o_s_ready   (s_ready),
        .i_s_data    (s_data),
        .i_s_last    (s_last),
        .i_flush     (flush),
        .o_wr_en     (wr_en),
        .o_wr_data   (wr_data),
        .i_wr_full   (wr_full),
        .o_busy      (busy),
        .o_word_cnt  (word_cnt),
        .o_stall_cnt (stall_cnt),
        .o_pad_cnt   (pad_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: bytes gathered for the current word, and committed
    // words not yet pushed (at most two fit in the packer).
    logic [7:0]  part_q[$];
    logic [63:0] words_q[$];
    int          m_words = 0, m_stalls = 0, m_pads = 0;

    typedef struct {
        logic        valid;
        logic [7:0]  data;
        logic        last;
        logic        flush;
        logic        full;
        logic        exp_en;
        logic [63:0] exp_data;
        logic        exp_ready;
        logic        exp_busy;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        part_q.delete();
        words_q.delete();
        m_words = 0;
        m_stalls = 0;
        m_pads = 0;
    endtask

    // Apply one clock edge of behaviour using the inputs as sampled at that edge
    task automatic model_edge();
        logic        rdy, acc, com;
        logic [63:0] w;
        rdy = (words_q.size() < 2);
        acc = s_valid && rdy;
        if (words_q.size() > 0 && wr_full) m_stalls++;
        if (words_q.size() > 0 && !wr_full) begin
            void'(words_q.pop_front());
            m_words++;
        end
        com = 1'b0;
        if (acc) begin
            part_q.push_back(s_data);
            com = (part_q.size() == LANES) || s_last || flush;
        end else begin
            com = rdy && flush && (part_q.size() > 0);
        end
        if (com) begin
            w = '0;
            for (int i = 0; i < LANES; i++) begin
                w[i*8 +: 8] = (i < part_q.size()) ? part_q[i] : 8'h00;
            end
            if (part_q.size() < LANES) m_pads++;
            words_q.push_back(w);
            part_q.delete();
        end
    endtask

    task automatic model_check();
        chk("wr_en", 64'(wr_en), 64'(words_q.size() > 0));
        if (words_q.size() > 0) chk("wr_data", wr_data, words_q[0]);
        chk("s_ready", 64'(s_ready), 64'(words_q.size() < 2));
        chk("busy", 64'(busy), 64'((part_q.size() > 0) || (words_q.size() > 0)));
        chk("word_cnt", 64'(word_cnt), 64'(m_words));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stalls));
        chk("pad_cnt", 64'(pad_cnt), 64'(m_pads));
    endtask

    // Drive one cycle of inputs (from a negedge), clock it, check at the next negedge
    task automatic step(input logic v, input logic [7:0] d, input logic l,
                        input logic f, input logic full);
        s_valid = v;
        s_data  = d;
        s_last  = l;
        flush   = f;
        wr_full = full;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        model_check();
    endtask

    task automatic addv(input logic v, input logic [7:0] d, input logic l, input logic f,
                        input logic en, input logic [63:0] ed, input logic bz);
        vec_t x;
        x.valid = v; x.data = d; x.last = l; x.flush = f; x.full = 1'b0;
        x.exp_en = en; x.exp_data = ed; x.exp_ready = 1'b1; x.exp_busy = bz;
        tbl.push_back(x);
    endtask

    initial begin
        // Directed vector table
        for (int k = 1; k <= 7; k++) addv(1'b1, 8'(k), 1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
        addv(1'b1, 8'h08, 1'b0, 1'b0, 1'b1, 64'h0807060504030201, 1'b1);
        addv(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
        addv(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
        addv(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
        addv(1'b1, 8'hCC, 1'b1, 1'b0, 1'b1, 64'h0000000000CCBBAA, 1'b1);
        addv(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
        addv(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
        for (int k = 1; k <= 4; k++) addv(1'b1, 8'(k), 1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
        addv(1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 64'h0000000504030201, 1'b1);
        addv(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
        for (int k = 1; k <= 7; k++) addv(1'b1, 8'(8'h10 + k), 1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
        addv(1'b1, 8'h18, 1'b1, 1'b0, 1'b1, 64'h1817161514131211, 1'b1);
        addv(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0);

        // Reset state
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_en", 64'(wr_en), 64'h0);
        chk("rst_wr_data", wr_data, 64'h0);
        chk("rst_ready", 64'(s_ready), 64'h1);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_cnts", 64'(word_cnt | stall_cnt | pad_cnt), 64'h0);
        rstn = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].valid, tbl[i].data, tbl[i].last, tbl[i].flush, tbl[i].full);
            chk("tbl_wr_en", 64'(wr_en), 64'(tbl[i].exp_en));
            if (tbl[i].exp_en) chk("tbl_wr_data", wr_data, tbl[i].exp_data);
            chk("tbl_ready", 64'(s_ready), 64'(tbl[i].exp_ready));
            chk("tbl_busy", 64'(busy), 64'(tbl[i].exp_busy));
        end
        chk("tbl_word_cnt", 64'(word_cnt), 64'd4);
        chk("tbl_pad_cnt", 64'(pad_cnt), 64'd2);

        // Reset with a word pending and a partial word in the accumulator
        for (int k = 1; k <= 13; k++) step(1'b1, 8'(k), 1'b0, 1'b0, 1'b1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_wr_en", 64'(wr_en), 64'h0);
        chk("mid_rst_busy", 64'(busy), 64'h0);
        chk("mid_rst_cnts", 64'(word_cnt | stall_cnt | pad_cnt), 64'h0);
        model_clear();
        s_valid = 1'b0;
        wr_full = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 8; k++) step(1'b1, 8'(8'h21 + k), 1'b0, 1'b0, 1'b0);
        chk("post_rst_word", wr_data, 64'h2827262524232221);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("post_rst_word_cnt", 64'(word_cnt), 64'd1);

        // Backpressure: 16 bytes stream while the FIFO stays full for 20 pending cycles
        for (int k = 1; k <= 16; k++) step(1'b1, 8'(k), 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 12; k++) step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
        chk("bp_ready", 64'(s_ready), 64'h0);
        chk("bp_stall_cnt", 64'(stall_cnt), 64'd20);
        chk("bp_first_word", wr_data, 64'h0807060504030201);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("bp_second_en", 64'(wr_en), 64'h1);
        chk("bp_second_word", wr_data, 64'h100F0E0D0C0B0A09);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("bp_word_cnt", 64'(word_cnt), 64'd3);
        chk("bp_idle", 64'(busy), 64'h0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 9) < 7), 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 9) < 3));
        end
        for (int n = 0; n < 4; n++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wr_byte_packer.md
# wr_byte_packer

Write-side front end for the 1-to-N asynchronous FIFO. Accepts a byte stream on a valid/ready handshake in the i_wr_clk domain, packs LANES consecutive bytes into one WR_WIDTH-bit word, and pushes each word into the FIFO write port under o_wr_full backpressure. A double buffer (accumulator plus output register) lets byte intake continue while a word waits on a full FIFO. Packet end or software flush pads and commits a partial word.

## Interface
Parameters:
- WIDTH, 8, byte/lane width; equals FIFO WIDTH
- WR_WIDTH, 64, packed word width; equals FIFO WR_WIDTH; must be an integer multiple of WIDTH
- LANES, WR_WIDTH/WIDTH, derived lanes per word; must be ≥2
- PAD, 8'h00, fill value for unused lanes on a partial commit
- CNT_W, 32, statistics counter width

Ports:
- i_wr_clk  in  1  write-domain clock
- i_wr_rstn  in  1  asynchronous, active-low reset
- i_s_valid  in  1  input byte valid
- o_s_ready  out  1  input byte accept
- i_s_data  in  WIDTH  input byte
- i_s_last  in  1  last byte of packet; commits the word, padded if needed
- i_flush  in  1  single-cycle request to commit a partial word
- o_wr_en  out  1  FIFO write request; drives FIFO i_wr_en
- o_wr_data  out  WR_WIDTH  packed word; drives FIFO i_wr_data
- i_wr_full  in  1  FIFO o_wr_full
- o_busy  out  1  accumulator non-empty, or a word is pending
- o_word_cnt  out  CNT_W  words pushed into the FIFO (saturating)
- o_stall_cnt  out  CNT_W  cycles with a word pending while the FIFO is full (saturating)
- o_pad_cnt  out  CNT_W  words committed with padding (saturating)

## Operation
- Byte accepted on i_s_valid && o_s_ready at a rising edge. Lane index lane ranges 0..LANES-1. The byte is written to acc[lane*WIDTH +: WIDTH]. Lane 0 is the LSB.
- Commit triggers:
  - An accepted byte at lane LANES-1.
  - An accepted byte with i_s_last.
  - i_flush with lane>0 and no byte accepted that cycle.
- On commit, lanes above the last written lane are filled with PAD. o_pad_cnt increments if any lane was padded. lane returns to 0.
- i_flush in the same cycle as an accepted byte: the byte goes in first, then the commit happens.
- i_flush with lane==0: no effect.
- Output register holds flag pend. A push happens when pend && !i_wr_full at a rising edge; pend then clears unless refilled in the same cycle.
- States:
  - FILL: accumulator accepting. On commit, if the output register is free or pushing this cycle, the word moves to the output register and pend=1; the state stays FILL. Otherwise go to WAIT.
  - WAIT: accumulator holds a complete word and o_s_ready=0. i_flush is ignored. When the output register pushes, the accumulator word transfers (pend stays 1) and the state returns to FILL.
- o_s_ready = (state==FILL).
- o_wr_en = pend. It is held stable, together with o_wr_data, until the push.
- Counters saturate at all-ones:
  - o_word_cnt +1 per push.
  - o_stall_cnt +1 per cycle with pend && i_wr_full.
- o_busy = (lane!=0) || pend || (state==WAIT).

## Timing
- Reset values:
  - All outputs 0, except o_s_ready=1 (state FILL).
  - lane=0; acc, counters and o_wr_data cleared.
- Reset mid-operation: the partial word and any pending word are discarded and nothing is written to the FIFO. The reset is asynchronous and the release is synchronous to i_wr_clk.
- Latency:
  - Committing byte at edge N → o_wr_en high from edge N, during cycle N+1.
  - With i_wr_full=0, the push occurs at edge N+1.
- Throughput: 1 byte/cycle sustained with no bubble while the FIFO is not full. Back-to-back words give o_wr_en high on consecutive push cycles only if commits are consecutive, e.g. successive single-byte packets.
- i_wr_full is sampled at the edge only; a full→not-full transition pushes on the next edge.

## Structure
- Shared package wr_pack_pkg:
  - Packer state enum {FILL, WAIT}.
  - Function lanes_f(WR_WIDTH, WIDTH).
  - Default PAD constant.
- Sub-module sat_counter (width CNT_W, inc enable, saturating); instantiated three times.
- Accumulator, lane counter, FSM and output register stay in the top module.

## Test plan
- Bytes 0x01..0x08 on consecutive cycles, i_wr_full=0 → o_wr_data=64'h0807060504030201, o_wr_en high for exactly 1 cycle, one cycle after the 8th byte; o_word_cnt=1.
- Bytes AA,BB,CC with i_s_last on CC → o_wr_data=64'h0000000000CCBBAA, o_pad_cnt=1, lane back to 0.
- i_wr_full=1 held 20 cycles while 16 bytes stream → first word pending, second word fills; then WAIT with o_s_ready=0. After release, two pushes with correct data in order; o_stall_cnt=20; no byte lost or duplicated.
- i_flush with lane=0 → no o_wr_en. i_flush in the same cycle as the 5th byte 0x05 → word 0x0000000504030201 committed, o_pad_cnt+1.
- i_s_last on lane 7 → one word, o_pad_cnt unchanged.
- Assert i_wr_rstn low after 5 bytes with a word pending → o_wr_en drops immediately, o_busy=0, counters 0. After release, 8 new bytes produce exactly one correct word.
